rcv_bit_timer: RTL

Parametrised bit-timing engine for the serial receiver datapath, sitting between the receive controller and the shift register. Once the controller raises `enable_timer` on the start-bit edge, the block counts a run-time bit period, strobes the shift register at the mid-point of each data bit and of the stop bit, then flags end of packet. It runs entirely on `clk`, with no derived clocks, and supports run-time bit period and data length, abort, and explicit re-arm.

---
 rtl/rcv_bit_timer_if.sv | 32 +++
 rtl/rcv_bit_timer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rcv_bit_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : rcv_bit_timer_if
// Purpose  : Controller <-> bit-timer signal bundle for the serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface rcv_bit_timer_if #(
    parameter int PERIOD_WIDTH = 8,
    parameter int MAX_BITS     = 16
);
    localparam int IDX_WIDTH = $clog2(MAX_BITS + 1);

    logic                    enable_timer;
    logic [PERIOD_WIDTH-1:0] bit_period;
    logic [IDX_WIDTH-1:0]    data_size;
    logic                    shift_strobe;
    logic [IDX_WIDTH-1:0]    bit_index;
    logic                    stop_sample;
    logic                    packet_done;
    logic                    busy;

    modport master (
        output enable_timer, bit_period, data_size,
        input  shift_strobe, bit_index, stop_sample, packet_done, busy
    );

    modport slave (
        input  enable_timer, bit_period, data_size,
        output shift_strobe, bit_index, stop_sample, packet_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/rcv_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : rcv_bit_timer
// Purpose  : Bit-period timer that strobes mid-bit samples and flags packet end.
// Revision : 1.0 - initial release
// ============================================================================
module rcv_bit_timer #(
    parameter int PERIOD_WIDTH = 8,
    parameter int MAX_BITS     = 16
) (
    input  wire logic         clk,
    input  wire logic         n_rst,
    rcv_bit_timer_if.slave    bus
);
    localparam int IDX_WIDTH = $clog2(MAX_BITS + 1);

    localparam logic [PERIOD_WIDTH-1:0] c_period_min = PERIOD_WIDTH'(2);
    localparam logic [PERIOD_WIDTH-1:0] c_period_one = PERIOD_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0]    c_size_max   = IDX_WIDTH'(MAX_BITS);
    localparam logic [IDX_WIDTH-1:0]    c_idx_one    = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH:0]      c_bit_one    = (IDX_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state, w_state_next;
    logic                    r_enable_prev;
    logic [PERIOD_WIDTH-1:0] r_period, w_period_next;
    logic [IDX_WIDTH-1:0]    r_size,   w_size_next;
    logic [PERIOD_WIDTH-1:0] r_phase,  w_phase_next;
    logic [IDX_WIDTH:0]      r_bit,    w_bit_next;
    logic                    r_strobe, w_strobe_next;
    logic [IDX_WIDTH-1:0]    r_index,  w_index_next;
    logic                    r_stop,   w_stop_next;
    logic                    r_done,   w_done_next;
    logic                    r_busy,   w_busy_next;

    logic                    w_start;
    logic                    w_wrap;
    logic [PERIOD_WIDTH-1:0] w_half;
    logic [PERIOD_WIDTH-1:0] w_phase_inc;
    logic [IDX_WIDTH:0]      w_bit_inc;
    logic [PERIOD_WIDTH-1:0] w_period_eff;
    logic [IDX_WIDTH-1:0]    w_size_eff;

    assign w_start      = bus.enable_timer && !r_enable_prev;
    assign w_half       = {1'b0, r_period[PERIOD_WIDTH-1:1]};
    assign w_wrap       = (r_phase == r_period - c_period_one);
    assign w_phase_inc  = w_wrap ? '0 : r_phase + c_period_one;
    assign w_bit_inc    = w_wrap ? r_bit + c_bit_one : r_bit;
    assign w_period_eff = (bus.bit_period < c_period_min) ? c_period_min : bus.bit_period;
    assign w_size_eff   = (bus.data_size == '0)        ? c_idx_one  :
                          (bus.data_size > c_size_max) ? c_size_max : bus.data_size;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_enable_prev <= 1'b0;
            r_period      <= '0;
            r_size        <= '0;
            r_phase       <= '0;
            r_bit         <= '0;
            r_strobe      <= 1'b0;
            r_index       <= '0;
            r_stop        <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_enable_prev <= bus.enable_timer;
            r_period      <= w_period_next;
            r_size        <= w_size_next;
            r_phase       <= w_phase_next;
            r_bit         <= w_bit_next;
            r_strobe      <= w_strobe_next;
            r_index       <= w_index_next;
            r_stop        <= w_stop_next;
            r_done        <= w_done_next;
            r_busy        <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_period_next = r_period;
        w_size_next   = r_size;
        w_phase_next  = r_phase;
        w_bit_next    = r_bit;
        w_strobe_next = 1'b0;
        w_index_next  = r_index;
        w_stop_next   = 1'b0;
        w_done_next   = 1'b0;
        w_busy_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_phase_next = '0;
                w_bit_next   = '0;
                if (w_start) begin
                    w_state_next  = S_RUN;
                    w_period_next = w_period_eff;
                    w_size_next   = w_size_eff;
                    w_busy_next   = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.enable_timer) begin
                    // Abort: anything that would have registered this edge is dropped.
                    w_state_next = S_IDLE;
                    w_phase_next = '0;
                    w_bit_next   = '0;
                end else if (r_stop) begin
                    // Stop strobe is on the outputs now, so the packet ends on this edge.
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b1;
                end else begin
                    w_phase_next = w_phase_inc;
                    w_bit_next   = w_bit_inc;
                    w_busy_next  = 1'b1;
                    if ((w_phase_inc == w_half) && (w_bit_inc != '0)) begin
                        w_strobe_next = 1'b1;
                        w_index_next  = w_bit_inc[IDX_WIDTH-1:0] - c_idx_one;
                        w_stop_next   = (w_bit_inc == ({1'b0, r_size} + c_bit_one));
                    end
                end
            end
            S_DONE: begin
                if (!bus.enable_timer) begin
                    w_state_next = S_IDLE;
                    w_phase_next = '0;
                    w_bit_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_phase_next = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    assign bus.shift_strobe = r_strobe;
    assign bus.bit_index    = r_index;
    assign bus.stop_sample  = r_stop;
    assign bus.packet_done  = r_done;
    assign bus.busy         = r_busy;
endmodule
`default_nettype wire
